// File: rtl/fifo_control.sv
// fifo_control: pointer, occupancy and flag controller for the
// 8-entry transaction-layer FIFO storage array.
module fifo_control #(
   parameter int PTR_W      = 3,
   parameter int ALMOST_FUL = 6,
   parameter int ALMOST_EMP = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   output logic             mem_wr_en,
   output logic             mem_rd_en,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             data_valid,
   output logic             overflow_err,
   output logic             underflow_err
);

   localparam logic [PTR_W:0] DEPTH_C = {1'b1, {PTR_W{1'b0}}};
   localparam logic [PTR_W:0] AF_C    = (PTR_W+1)'(ALMOST_FUL);
   localparam logic [PTR_W:0] AE_C    = (PTR_W+1)'(ALMOST_EMP);

   logic wr_acc;
   logic rd_acc;

   // flags decode the registered count; acceptance uses pre-update count
   always_comb begin
      full         = (count == DEPTH_C);
      empty        = (count == '0);
      almost_full  = (count >= AF_C);
      almost_empty = (count <= AE_C);
      wr_acc       = push & ~full & ~reset;
      rd_acc       = pop & ~empty & ~reset;
      mem_wr_en    = wr_acc;
      mem_rd_en    = rd_acc;
   end

   // pointer, occupancy, read-valid pipeline and sticky error state
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         data_valid    <= 1'b0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         data_valid    <= rd_acc;
         overflow_err  <= overflow_err | (push & full);
         underflow_err <= underflow_err | (pop & empty);
      end
   end

endmodule
